// File: rtl/enc_32_5_seq_pkg.sv
// Shared definitions for the sequential 32->5 encoder: FSM state encoding and
// the default vector/index widths.
package enc_32_5_seq_pkg;

  localparam int N_DEF = 32;
  localparam int W_DEF = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/enc_32_5_seq_penc.sv
// Combinational LSB-first priority encoder: index of the lowest set bit, plus
// any-set and exactly-one-set flags.
module penc_32_5 #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         single
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Scan from the top down so the lowest set bit is the one left standing.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/enc_32_5_seq.sv
// Sequential multi-hot to binary encoder: accepts a request vector and emits
// the index of each set bit, lowest first, one per output handshake.
module enc_32_5_seq
  import enc_32_5_seq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [N-1:0] in_vec,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  input  logic         out_ready
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   enc_idx;
  logic           enc_any;
  logic           enc_single;
  logic           fire_out;
  logic           accept;

  penc_32_5 #(.N(N), .W(W)) u_penc (
    .vec    (pending_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  // Outputs come only from the pending register, never from in_*.
  assign out_valid = (state_q == BUSY);
  assign out_idx   = (out_valid && enc_any) ? enc_idx : '0;
  assign out_last  = out_valid && enc_single;

  assign fire_out = out_valid && out_ready;
  assign in_ready = (state_q == IDLE) || (fire_out && out_last);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // An all-zero vector is consumed without ever leaving IDLE.
          if (accept && (in_vec != '0)) begin
            pending_d = in_vec;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (fire_out) begin
            pending_d = pending_q & ~(ONE << out_idx);
            if (out_last) begin
              // A vector taken on the final handshake keeps the pipe full.
              if (accept && (in_vec != '0)) begin
                pending_d = in_vec;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: begin
          state_d   = IDLE;
          pending_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule
